// File: rtl/sc_stream_to_binary_pkg.sv
// Shared definitions for the stochastic-to-binary converter: FSM encodings and window sizing.
package sc_stream_to_binary_pkg;

    localparam logic S2B_IDLE  = 1'b0;
    localparam logic S2B_COUNT = 1'b1;

    // Number of qualified bits in one window of log2 length w.
    function automatic int unsigned sc_window(input int unsigned w);
        return 32'd1 << w;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Counts qualified bits and qualified 1s over one window of 2^WIDTH samples.
module sc_window_counter
    import sc_stream_to_binary_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sample,
    output logic [WIDTH:0]   ones_cnt,
    output logic             last
);

    localparam logic [WIDTH-1:0] BIT_MAX = WIDTH'(sc_window(WIDTH) - 1);

    logic [WIDTH-1:0] bit_cnt;

    assign last = en && (bit_cnt == BIT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (clr) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
        end else if (en) begin
            bit_cnt  <= bit_cnt + WIDTH'(1);
            ones_cnt <= ones_cnt + (WIDTH+1)'(sample);
        end
    end

endmodule

// File: rtl/sc_stream_to_binary.sv
// Converts a stochastic bitstream into a binary count of 1s per 2^WIDTH-bit window,
// presented on a valid/ready output with a sticky overrun flag.
module sc_stream_to_binary
    import sc_stream_to_binary_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit CONT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             busy,
    output logic [WIDTH:0]   out_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    logic           state;
    logic           cnt_en;
    logic           cnt_clr;
    logic           last;
    logic [WIDTH:0] ones_cnt;

    assign busy    = (state == S2B_COUNT);
    assign cnt_en  = busy && in_valid;
    // Holding the counters clear while idle gives a zeroed window on entry;
    // clearing on the last bit lets a continuous run start the next window with no dead cycle.
    assign cnt_clr = !busy || last;

    sc_window_counter #(.WIDTH(WIDTH)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .sample   (in_bit),
        .ones_cnt (ones_cnt),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S2B_IDLE;
            out_value <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == S2B_IDLE) begin
                if (start || CONT)
                    state <= S2B_COUNT;
            end else if (last && !CONT) begin
                state <= S2B_IDLE;
            end

            // A completing window always wins; an accept in the same cycle just frees the slot.
            if (last) begin
                out_value <= ones_cnt + (WIDTH+1)'(in_bit);
                out_valid <= 1'b1;
                if (out_valid && !out_ready)
                    overrun <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Directed bench: one CONT=0 and one CONT=1 converter, scoreboard queues popped on each accept.
module tb_sc_stream_to_binary;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start0, bit0, valid0, ready0, busy0, out_valid0, overrun0;
    logic [W:0]   out_value0;
    logic         start1, bit1, valid1, ready1, busy1, out_valid1, overrun1;
    logic [W:0]   out_value1;

    int n_checks = 0;
    int n_pass   = 0;
    int exp0[$];
    int exp1[$];
    int e0, e1;

    sc_stream_to_binary #(.WIDTH(W), .CONT(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .in_bit(bit0), .in_valid(valid0),
        .busy(busy0), .out_value(out_value0), .out_valid(out_valid0),
        .out_ready(ready0), .overrun(overrun0)
    );

    sc_stream_to_binary #(.WIDTH(W), .CONT(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_bit(bit1), .in_valid(valid1),
        .busy(busy1), .out_value(out_value1), .out_valid(out_valid1),
        .out_ready(ready1), .overrun(overrun1)
    );

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Scoreboard monitors: compare on every accepted result.
    always @(negedge clk) begin
        if (rst && out_valid0 && ready0) begin
            check("s0_result_expected", int'(exp0.size() > 0), 1);
            if (exp0.size() > 0) begin
                e0 = exp0.pop_front();
                check("s0_value", int'(out_value0), e0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && out_valid1 && ready1) begin
            check("s1_result_expected", int'(exp1.size() > 0), 1);
            if (exp1.size() > 0) begin
                e1 = exp1.pop_front();
                check("s1_value", int'(out_value1), e1);
            end
        end
    end

    // mode 0: zeros (start at window end), 1: ones, 2: alternating (start mid-window), 3: ones with 50% valid
    task automatic window0(input int mode, input int expv, input int lat, input logic rdy);
        int edges;
        int k;
        exp0.push_back(expv);
        ready0 = rdy;
        start0 = 1'b1; valid0 = 1'b0; bit0 = 1'b0;
        @(posedge clk); #1;
        start0 = 1'b0;
        edges = 1;
        k = 0;
        while (!out_valid0 && edges < 200) begin
            case (mode)
                0: begin valid0 = 1'b1; bit0 = 1'b0; start0 = (k == 15); end
                1: begin valid0 = 1'b1; bit0 = 1'b1; end
                2: begin valid0 = 1'b1; bit0 = (k % 2 == 0); start0 = (k == 5); end
                default: begin valid0 = (k % 2 == 0); bit0 = 1'b1; end
            endcase
            @(posedge clk); #1;
            edges++;
            k++;
        end
        valid0 = 1'b0; bit0 = 1'b0; start0 = 1'b0;
        check("s0_latency", edges, lat);
        check("s0_busy_falls", int'(busy0), 0);
        if (!rdy) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("s0_hold_value", int'(out_value0), expv);
                check("s0_hold_valid", int'(out_valid0), 1);
            end
            ready0 = 1'b1;
        end
        @(posedge clk); #1;
        ready0 = 1'b0;
        check("s0_valid_drops", int'(out_valid0), 0);
        check("s0_stays_idle", int'(busy0), 0);
    endtask

    // mode 0: ones, 1: 1010..., 2: 1000 repeating; ready only in the final bit cycle
    task automatic feed1(input int mode, input logic rdy_last);
        for (int i = 0; i < 16; i++) begin
            valid1 = 1'b1;
            bit1   = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : (i % 4 == 0);
            ready1 = (i == 15) ? rdy_last : 1'b0;
            @(posedge clk); #1;
        end
        valid1 = 1'b0; bit1 = 1'b0; ready1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start0 = 1'b0; bit0 = 1'b0; valid0 = 1'b0; ready0 = 1'b0;
        start1 = 1'b0; bit1 = 1'b0; valid1 = 1'b0; ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy0", int'(busy0), 0);
        check("rst_valid0", int'(out_valid0), 0);
        check("rst_value0", int'(out_value0), 0);
        check("rst_overrun0", int'(overrun0), 0);
        check("rst_busy1", int'(busy1), 0);
        check("rst_valid1", int'(out_valid1), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("cont_auto_start", int'(busy1), 1);
        check("nocont_waits", int'(busy0), 0);

        window0(1, 16, 17, 1'b0);   // all ones, held result
        window0(0, 0, 17, 1'b1);    // all zeros, start at window end ignored
        window0(2, 8, 17, 1'b1);    // alternating, start during COUNT ignored
        window0(3, 16, 32, 1'b1);   // 50% qualified ones

        // Reset after 7 qualified bits discards the partial window.
        start0 = 1'b1; valid0 = 1'b1; bit0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0; valid0 = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy0), 0);
        check("midrst_valid", int'(out_valid0), 0);
        check("midrst_value", int'(out_value0), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        window0(1, 16, 17, 1'b1);

        // CONT=1: two unconsumed windows overwrite and flag overrun.
        feed1(0, 1'b0);
        check("c_first_valid", int'(out_valid1), 1);
        check("c_first_value", int'(out_value1), 16);
        check("c_first_overrun", int'(overrun1), 0);
        check("c_still_busy", int'(busy1), 1);
        exp1.push_back(8);
        feed1(1, 1'b0);
        check("c_overwrite_value", int'(out_value1), 8);
        check("c_overrun_set", int'(overrun1), 1);
        ready1 = 1'b1;
        @(posedge clk); #1;
        ready1 = 1'b0;
        check("c_valid_drops", int'(out_valid1), 0);
        check("c_overrun_sticky", int'(overrun1), 1);

        // Accept coinciding with completion: no overrun.
        rst = 1'b0;
        @(posedge clk); #1;
        check("c_rst_overrun", int'(overrun1), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp1.push_back(16);
        feed1(0, 1'b0);
        feed1(2, 1'b1);
        check("c_simul_value", int'(out_value1), 4);
        check("c_simul_valid", int'(out_valid1), 1);
        check("c_simul_overrun", int'(overrun1), 0);
        exp1.push_back(4);
        ready1 = 1'b1;
        @(posedge clk); #1;
        ready1 = 1'b0;
        check("c_final_drop", int'(out_valid1), 0);

        repeat (3) @(posedge clk);
        #1;
        check("s0_queue_drained", exp0.size(), 0);
        check("s1_queue_drained", exp1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
